// File: rtl/rotl_seq_unit.sv
// Sequential rotate-left unit: one bit position per clock, valid/ready on
// both sides. Inverts the combinational rotate-right barrel shifter.
module rotl_seq_unit #(
    parameter int WIDTH = 4,
    parameter int SHW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    cnt_d   = amt;
                    state_d = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A pending input word is not accepted here; it waits for IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign data_out  = data_q;

endmodule

// File: tb/tb_rotl_seq_unit.sv
// Directed bench for rotl_seq_unit: reset, latency, backpressure,
// mid-operation reset and the rotate-right inverse sweep.
module tb_rotl_seq_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data_in;
    logic [1:0] amt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] data_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    rotl_seq_unit #(.WIDTH(4), .SHW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .amt      (amt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rotr(input logic [3:0] x, input int s);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = x[(i + s) % 4];
        return r;
    endfunction

    // Accept one word, measure edges to out_valid, check result, then drain.
    task automatic run(input string tag, input logic [3:0] d,
                       input logic [1:0] a, input logic [3:0] exp);
        int n;
        in_valid = 1'b1;
        data_in  = d;
        amt      = a;
        tick();
        in_valid = 1'b0;
        data_in  = ~d;
        amt      = ~a;
        check({tag, "_busy"}, {7'd0, busy}, 8'd1);
        check({tag, "_inrdy"}, {7'd0, in_ready}, 8'd0);
        n = 0;
        while (!out_valid && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 8'(n), 8'(a));
        check({tag, "_data"}, {4'd0, data_out}, {4'd0, exp});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_vld"}, {7'd0, out_valid}, 8'd0);
        check({tag, "_idle_rdy"}, {7'd0, in_ready}, 8'd1);
        check({tag, "_hold"}, {4'd0, data_out}, {4'd0, exp});
    endtask

    initial begin
        int n;
        int seen;
        logic [3:0] y;
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = 4'h0;
        amt       = 2'd0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_data", {4'd0, data_out}, 8'd0);
        check("rst_vld", {7'd0, out_valid}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_rdy", {7'd0, in_ready}, 8'd1);

        tick();
        check("idle_hold", {7'd0, busy}, 8'd0);

        run("r1", 4'b1000, 2'd1, 4'b0001);
        run("r2", 4'b1011, 2'd2, 4'b1110);
        run("r3", 4'b1011, 2'd3, 4'b1101);
        run("r0", 4'b0110, 2'd0, 4'b0110);

        // Backpressure: result must wait, inputs ignored.
        in_valid = 1'b1;
        data_in  = 4'b1001;
        amt      = 2'd1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            data_in  = 4'(i);
            amt      = 2'(i);
            check("bp_vld", {7'd0, out_valid}, 8'd1);
            check("bp_data", {4'd0, data_out}, 8'b0011);
            check("bp_rdy", {7'd0, in_ready}, 8'd0);
            tick();
        end
        in_valid  = 1'b1;
        data_in   = 4'b1111;
        amt       = 2'd2;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_exit_vld", {7'd0, out_valid}, 8'd0);
        check("bp_exit_rdy", {7'd0, in_ready}, 8'd1);
        check("bp_exit_data", {4'd0, data_out}, 8'b0011);
        tick();
        check("bp_no_accept", {7'd0, busy}, 8'd0);

        // Reset while shifting drops the word.
        seen     = 0;
        in_valid = 1'b1;
        data_in  = 4'b0101;
        amt      = 2'd3;
        tick();
        in_valid = 1'b0;
        if (out_valid) seen++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_data", {4'd0, data_out}, 8'd0);
        check("mid_vld", {7'd0, out_valid}, 8'd0);
        check("mid_busy", {7'd0, busy}, 8'd0);
        check("mid_rdy", {7'd0, in_ready}, 8'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_no_out", 8'(seen), 8'd0);

        // Inverse sweep with random gaps and stalls.
        for (int x = 0; x < 16; x++) begin
            for (int s = 0; s < 4; s++) begin
                repeat ($urandom_range(0, 2)) tick();
                y        = rotr(4'(x), s);
                in_valid = 1'b1;
                data_in  = y;
                amt      = 2'(s);
                tick();
                in_valid = 1'b0;
                n = 0;
                while (!out_valid && n < 8) begin
                    tick();
                    n++;
                end
                check("inv_lat", 8'(n), 8'(s));
                repeat ($urandom_range(0, 3)) tick();
                check("inv_data", {4'd0, data_out}, 8'(x));
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rotl_seq_unit.md
Name: rotl_seq_unit

Overview:
- Multi-cycle rotate-left unit.
- Undoes the team's combinational 4-bit rotate-right barrel shifter: rotating right by amt, then feeding the result through this block with the same amt, returns the original word.
- Rotates one bit position per clock, using a small FSM and a down-counter.
- Valid/ready handshakes on input and output, so it sits between pipeline stages in the datapath.

Parameters:
- WIDTH, 4: data word width. Must be a power of 2 and at least 2.
- SHW, 2: rotate-amount width. Must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  data_in/amt are valid
- in_ready  output  1  block can accept a new word; high only in IDLE
- data_in  input  WIDTH  word to rotate
- amt  input  SHW  rotate-left amount, 0..WIDTH-1
- out_valid  output  1  data_out holds the result
- out_ready  input  1  downstream accepts the result
- data_out  output  WIDTH  rotated word, registered
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
  - All state updates on rising clk.
  - rst sampled high at an edge overrides every other input.
- Reset values:
  - state = IDLE
  - data_out = 0
  - out_valid = 0
  - busy = 0
  - in_ready = 1 in the cycle after the reset edge
  - internal count = 0
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready = 1. On an edge with in_valid && in_ready:
    - load the data register with data_in and count with amt;
    - if amt == 0, go to DONE;
    - otherwise go to SHIFT.
    - With in_valid = 0, stay in IDLE.
  - SHIFT: each edge does data <= {data[WIDTH-2:0], data[WIDTH-1]} and count <= count - 1.
    - When count == 1 at the edge, go to DONE.
    - Inputs are ignored and in_ready = 0.
  - DONE: out_valid = 1.
    - data_out is stable and inputs are ignored while out_ready = 0.
    - On an edge with out_ready = 1, go to IDLE and clear out_valid.
- Latency: with acceptance at edge k, out_valid rises at edge k+amt.
  - amt = 0 gives out_valid in the cycle directly after the acceptance edge.
  - Worst case is WIDTH-1 edges.
- Throughput: no overlap. in_ready is low from the acceptance edge until the edge that completes the output handshake.
  - IDLE is held for at least one cycle between words.
  - Minimum period per word is amt+2 cycles.
- data_out is the data register itself, with no combinational path from the inputs.
  - It holds its last value in IDLE; only rst clears it.
- out_valid is not cleared while out_ready stays low; the result waits indefinitely.
- amt is only sampled at acceptance. Later changes on amt or data_in have no effect.
- Reset mid-operation (SHIFT or DONE): the word is dropped with no partial output. Registers return to their reset values at that edge.
- Simultaneous in_valid and out_ready in DONE: only the output handshake occurs. The new word waits for IDLE.
- Inverse property: for every x and every s in 0..WIDTH-1, rotl_seq_unit(rotr(x,s), s) == x. Here rotr(x,s) gives output bit i = x[(i+s) mod WIDTH].

Test Plan:
- Reset check: hold rst for 2 edges, then release -> data_out = 0, out_valid = 0, busy = 0, in_ready = 1.
- Directed rotations (WIDTH = 4):
  - data_in = 4'b1000, amt = 1 -> out_valid at edge k+1, data_out = 4'b0001.
  - 4'b1011, amt = 2 -> 4'b1110 at edge k+2.
  - 4'b1011, amt = 3 -> 4'b1101 at edge k+3.
- Zero amount: data_in = 4'b0110, amt = 0 -> out_valid in the cycle after acceptance, data_out = 4'b0110, busy = 1.
- Backpressure: hold out_ready = 0 for 10 cycles after 4'b1001, amt = 1 completes.
  - data_out must stay 4'b0011 with out_valid = 1 throughout.
  - in_ready must stay 0 and in_valid pulses must be ignored.
  - Raise out_ready -> IDLE on the next edge.
- Reset mid-op: accept 4'b0101, amt = 3, then assert rst at edge k+1 -> all outputs at reset values the following cycle; no out_valid pulse ever appears.
- Inverse sweep: drive the existing rotate-right shifter with all 16 x 4 (x, s) pairs and feed each SHO into this block with amt = s.
  - Every data_out must equal x.
  - Use random out_ready stalls and random in_valid gaps.
